prog_fir_single_chan_mac: RTL and testbench
===========================================

PROG_FIR_SINGLE_CHAN_MAC -- requirements
Module: prog_fir_single_chan_mac

Interface
REQ-001 Parameter NTAPS, default 32, tap count, range 2..1024.
REQ-002 Parameter DATA_W, default 16, signed input sample width.
REQ-003 Parameter COEF_W, default 16, signed coefficient width, taken from coef_data[COEF_W-1:0].
REQ-004 Parameter OUT_W, default 32, signed output width.
REQ-005 Parameter SHIFT, default 15, arithmetic right shift applied to accumulator before output.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  input sample strobe.
REQ-009 in_data  in  DATA_W  signed input sample.
REQ-010 in_ready  out  1  block accepts a sample this cycle.
REQ-011 coef_en  out  1  coefficient RAM read enable.
REQ-012 coef_addr  out  10  coefficient RAM word address (tap index).
REQ-013 coef_data  in  32  coefficient RAM read data, valid 2 cycles after address/enable.
REQ-014 out_valid  out  1  single-cycle result strobe.
REQ-015 out_data  out  OUT_W  signed filtered result.
REQ-016 sat_flag  out  1  sticky saturation indicator.

Function
REQ-017 Sample accepted SHALL be the cycle in_valid && in_ready; in_valid while in_ready=0 SHALL be ignored (upstream holds).
REQ-018 States SHALL be IDLE (in_ready=1), MAC, DRAIN, OUT; IDLE->MAC on accept, MAC->DRAIN after tap NTAPS-1 issued, DRAIN->OUT after 2 cycles, OUT->IDLE after 1 cycle.
REQ-019 Accepted sample SHALL be written to an NTAPS-deep circular history buffer; write pointer wraps NTAPS-1 -> 0.
REQ-020 Accept at cycle 0: coef_addr=k with coef_en=1 at cycle 1+k, k=0..NTAPS-1; coef_en=0 otherwise.
REQ-021 Coefficient k SHALL multiply x[n-k] (k=0 is the sample just accepted); history read delayed 2 cycles to align with coef_data.
REQ-022 Accumulator width SHALL be DATA_W+COEF_W+clog2(NTAPS), cleared at accept, full-precision signed products.
REQ-023 out_valid SHALL pulse for exactly one cycle at cycle NTAPS+3; out_data held until next result.
REQ-024 in_ready SHALL return high at cycle NTAPS+4; throughput one sample per NTAPS+4 cycles.
REQ-025 out_data SHALL be (acc >>> SHIFT) truncated to low OUT_W bits (wrap) unless REQ-032 applies.
REQ-026 coef_addr bits above clog2(NTAPS) SHALL be zero.

Reset
REQ-027 rst SHALL return state to IDLE within the same edge, aborting any MAC in progress without producing out_valid.
REQ-028 Reset values: in_ready=1 on the first cycle after reset, coef_en=0, coef_addr=0, out_valid=0, out_data=0, sat_flag=0.
REQ-029 rst SHALL clear the history buffer to zero and the write pointer to 0.
REQ-030 A sample presented during the cycle rst=1 SHALL be discarded.

Configuration
REQ-031 Macro PROG_FIR_SAT_EN SHALL select output saturation.
REQ-032 With PROG_FIR_SAT_EN defined: shifted accumulator outside OUT_W range SHALL clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1) and set sat_flag (sticky until rst).
REQ-033 Without PROG_FIR_SAT_EN: wrap per REQ-025, sat_flag tied 0, no saturation logic synthesized.

Verification
REQ-034 Impulse: SHIFT=0, coef[k]=k+1, input 1 then 31 zeros -> outputs 1,2,...,32, then 0.
REQ-035 Step: SHIFT=0, all coef=1, 40 inputs of 100 -> outputs 100,200,...,3200, then 3200 steady.
REQ-036 Timing: accept at cycle 0 -> coef_addr 0..31 at cycles 1..32, out_valid only at cycle 35, in_ready high at 36; in_valid held high during busy accepted only at 36.
REQ-037 Reset mid-MAC: assert rst at cycle 10 -> no out_valid, next impulse reproduces REQ-034 with zero history.
REQ-038 Saturation: OUT_W=16, SHIFT=0, all coef=32767, inputs 32767 -> with PROG_FIR_SAT_EN out_data=32767 and sat_flag=1; without, wrapped low 16 bits and sat_flag=0.

Source files
------------

// File: rtl/prog_fir_single_chan_mac.sv
// prog_fir_single_chan_mac: single-channel programmable FIR filter.
// A single multiplier is time-shared across NTAPS taps, one tap per cycle.
// Coefficients come from an external RAM with 2-cycle read latency.
// Each accepted sample costs NTAPS+4 cycles: NTAPS issue cycles, 2 drain
// cycles, 1 output cycle and 1 idle cycle.
// Optional macro PROG_FIR_SAT_EN: clamps the output to the OUT_W range and
// keeps a sticky sat_flag. Without it the output wraps and sat_flag is 0.
//
// state   | meaning
// S_IDLE  | in_ready=1, waiting for a sample
// S_MAC   | issuing coefficient reads for taps 0..NTAPS-1
// S_DRAIN | waiting 2 cycles for the last coefficient to return
// S_OUT   | out_valid pulse, result on out_data
`timescale 1ns/1ps

module prog_fir_single_chan_mac #(
  parameter int NTAPS  = 32,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     coef_en,
  output logic [9:0]               coef_addr,
  input  logic [31:0]              coef_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     sat_flag
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                    state;
  logic [AW-1:0]             tap_cnt;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      drain_cnt;
  logic                      accept;

  logic signed [DATA_W-1:0]  hist [NTAPS];
  logic signed [DATA_W-1:0]  x_d1;
  logic signed [DATA_W-1:0]  x_d2;
  logic                      v_d1;
  logic                      v_d2;
  logic signed [COEF_W-1:0]  coef_s;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_sh;
  logic signed [OUT_W-1:0]   out_wrap;
  logic                      load_out;

  // in_ready is a registered copy of "state is IDLE", so accept needs no decode
  assign accept = in_valid && in_ready;

  assign coef_s   = coef_data[COEF_W-1:0];
  assign prod     = x_d2 * coef_s;
  // The final product is folded in combinationally so the result can be
  // registered on the same edge that consumes the last coefficient.
  assign acc_sum  = acc + (v_d2 ? ACC_W'(prod) : '0);
  assign acc_sh   = acc_sum >>> SHIFT;
  assign out_wrap = OUT_W'(acc_sh);
  assign load_out = (state == S_DRAIN) && drain_cnt;

  generate
    if (COEF_W < 32) begin : g_coef_hi
      logic unused_coef_hi;
      assign unused_coef_hi = ^coef_data[31:COEF_W];
    end
  endgenerate

  logic unused_acc_sh;
  assign unused_acc_sh = ^acc_sh;

  // Control FSM: sequences tap issue, drain and the output strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      coef_en   <= 1'b0;
      coef_addr <= '0;
      tap_cnt   <= '0;
      rd_ptr    <= '0;
      drain_cnt <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_MAC;
            in_ready  <= 1'b0;
            coef_en   <= 1'b1;
            coef_addr <= '0;
            tap_cnt   <= '0;
            rd_ptr    <= wr_ptr;
          end
        end
        S_MAC: begin
          rd_ptr <= (rd_ptr == '0) ? LAST_TAP : rd_ptr - AW'(1);
          if (tap_cnt == LAST_TAP) begin
            state     <= S_DRAIN;
            coef_en   <= 1'b0;
            coef_addr <= '0;
            drain_cnt <= 1'b0;
          end else begin
            tap_cnt   <= tap_cnt + AW'(1);
            coef_addr <= 10'(tap_cnt + AW'(1));
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          coef_en  <= 1'b0;
        end
      endcase
    end
  end

  // Sample history: circular buffer, newest sample at wr_ptr before increment
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
      wr_ptr <= '0;
    end else if (accept) begin
      hist[wr_ptr] <= in_data;
      wr_ptr       <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + AW'(1);
    end
  end

  // Datapath: delay history read 2 cycles to meet coef_data, then accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      x_d1 <= '0;
      x_d2 <= '0;
      v_d1 <= 1'b0;
      v_d2 <= 1'b0;
      acc  <= '0;
    end else begin
      x_d1 <= hist[rd_ptr];
      x_d2 <= x_d1;
      v_d1 <= coef_en;
      v_d2 <= v_d1;
      acc  <= accept ? '0 : acc_sum;
    end
  end

`ifdef PROG_FIR_SAT_EN
  logic sat_hi;
  logic sat_lo;

  generate
    if (ACC_W > OUT_W) begin : g_sat
      assign sat_hi = !acc_sh[ACC_W-1] && (|acc_sh[ACC_W-2:OUT_W-1]);
      assign sat_lo =  acc_sh[ACC_W-1] && !(&acc_sh[ACC_W-2:OUT_W-1]);
    end else begin : g_nosat
      assign sat_hi = 1'b0;
      assign sat_lo = 1'b0;
    end
  endgenerate

  // Output register with clamp to the signed OUT_W range; sat_flag is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      sat_flag <= 1'b0;
    end else if (load_out) begin
      if (sat_hi) begin
        out_data <= {1'b0, {(OUT_W-1){1'b1}}};
        sat_flag <= 1'b1;
      end else if (sat_lo) begin
        out_data <= {1'b1, {(OUT_W-1){1'b0}}};
        sat_flag <= 1'b1;
      end else begin
        out_data <= out_wrap;
      end
    end
  end
`else
  assign sat_flag = 1'b0;

  // Output register: shifted accumulator wraps to the low OUT_W bits
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (load_out) begin
      out_data <= out_wrap;
    end
  end
`endif

endmodule

// File: tb/tb_prog_fir_single_chan_mac.sv
// Directed bench for prog_fir_single_chan_mac. DUT "a" (OUT_W=32, SHIFT=0)
// covers impulse, step, cycle timing and mid-MAC reset; DUT "b"
// (OUT_W=16, SHIFT=0) covers the saturation / wrap behaviour.
`timescale 1ns/1ps

module tb_prog_fir_single_chan_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               a_in_valid;
  logic signed [15:0] a_in_data;
  logic               a_in_ready;
  logic               a_coef_en;
  logic [9:0]         a_coef_addr;
  logic [31:0]        a_coef_data = '0;
  logic               a_out_valid;
  logic signed [31:0] a_out_data;
  logic               a_sat_flag;

  logic               b_in_valid;
  logic signed [15:0] b_in_data;
  logic               b_in_ready;
  logic               b_coef_en;
  logic [9:0]         b_coef_addr;
  logic [31:0]        b_coef_data = '0;
  logic               b_out_valid;
  logic signed [15:0] b_out_data;
  logic               b_sat_flag;

  logic [31:0] a_mem [32];
  logic [31:0] b_mem [32];
  logic [31:0] a_d1 = '0;
  logic [31:0] b_d1 = '0;

  int n_cmp = 0;
  int n_err = 0;

  prog_fir_single_chan_mac #(
    .NTAPS(32), .DATA_W(16), .COEF_W(16), .OUT_W(32), .SHIFT(0)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .coef_en(a_coef_en), .coef_addr(a_coef_addr),
    .coef_data(a_coef_data), .out_valid(a_out_valid), .out_data(a_out_data),
    .sat_flag(a_sat_flag)
  );

  prog_fir_single_chan_mac #(
    .NTAPS(32), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .coef_en(b_coef_en), .coef_addr(b_coef_addr),
    .coef_data(b_coef_data), .out_valid(b_out_valid), .out_data(b_out_data),
    .sat_flag(b_sat_flag)
  );

  // Coefficient RAMs with 2-cycle read latency
  always @(posedge clk) begin
    if (a_coef_en) a_d1 <= a_mem[a_coef_addr[4:0]];
    a_coef_data <= a_d1;
    if (b_coef_en) b_d1 <= b_mem[b_coef_addr[4:0]];
    b_coef_data <= b_d1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send one sample to DUT a (sel=0) or b (sel=1) and check its result
  task automatic run(input bit sel, input int din, input longint exp, input string tag);
    int t;
    t = 0;
    while (!(sel ? b_in_ready : a_in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(sel ? b_in_ready : a_in_ready))
      chk({tag, "_ready_timeout"}, sel ? b_in_ready : a_in_ready, 1);
    if (sel) begin
      b_in_valid = 1'b1;
      b_in_data  = din[15:0];
    end else begin
      a_in_valid = 1'b1;
      a_in_data  = din[15:0];
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    t = 0;
    while (!(sel ? b_out_valid : a_out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ov"}, sel ? b_out_valid : a_out_valid, 1);
    chk(tag, sel ? 64'(b_out_data) : 64'(a_out_data), exp);
    @(negedge clk);
    chk({tag, "_pulse"}, sel ? b_out_valid : a_out_valid, 0);
    chk({tag, "_hold"}, sel ? 64'(b_out_data) : 64'(a_out_data), exp);
  endtask

  task automatic impulse(input string pfx);
    for (int n = 0; n <= 32; n++)
      run(1'b0, (n == 0) ? 1 : 0, (n < 32) ? longint'(n + 1) : 0,
          $sformatf("%s%0d", pfx, n));
  endtask

  initial begin
    logic [12:0] exp_vec;
    logic        e_en;
    logic [9:0]  e_addr;
    int          ov_cnt;

    a_in_data = '0;
    b_in_data = '0;
    for (int k = 0; k < 32; k++) begin
      a_mem[k] = 32'(k + 1);
      b_mem[k] = 32'd32767;
    end

    // Reset state
    do_reset();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_coef_en", a_coef_en, 0);
    chk("rst_coef_addr", a_coef_addr, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_sat_flag", a_sat_flag, 0);
    chk("rst_b_sat_flag", b_sat_flag, 0);

    // Impulse: coef[k]=k+1 gives 1..32 then 0
    impulse("imp");

    // Step: all coefficients 1, input 100
    do_reset();
    for (int k = 0; k < 32; k++) a_mem[k] = 32'd1;
    for (int n = 0; n < 40; n++)
      run(1'b0, 100, 100 * ((n < 32) ? n + 1 : 32), $sformatf("step%0d", n));

    // Cycle timing with in_valid held high through the busy period
    do_reset();
    for (int k = 0; k < 32; k++) a_mem[k] = 32'(k + 1);
    chk("tim_ready0", a_in_ready, 1);
    a_in_valid = 1'b1;
    a_in_data  = 16'sd5;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      e_en    = (c >= 1 && c <= 32) || (c >= 37 && c <= 40);
      e_addr  = !e_en ? 10'd0 : (c <= 32) ? 10'(c - 1) : 10'(c - 37);
      exp_vec = {(c == 36), e_en, (c == 35), e_addr};
      chk($sformatf("tim_c%0d", c),
          {a_in_ready, a_coef_en, a_out_valid, a_coef_addr}, exp_vec);
      if (c == 35) chk("tim_data", a_out_data, 5);
    end
    a_in_valid = 1'b0;

    // Reset mid-MAC, with a sample offered while rst is high
    do_reset();
    a_in_valid = 1'b1;
    a_in_data  = 16'sd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) a_in_valid = 1'b0;
    end
    rst        = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 16'sd555;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    a_in_valid = 1'b0;
    chk("mid_rst_ready", a_in_ready, 1);
    chk("mid_rst_coef_en", a_coef_en, 0);
    ov_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_out_valid) ov_cnt++;
      @(negedge clk);
    end
    chk("mid_rst_no_ov", ov_cnt, 0);
    impulse("rimp");

    // Saturation / wrap on the 16-bit output instance
    do_reset();
`ifdef PROG_FIR_SAT_EN
    run(1'b1, 32767, 32767, "sat1");
    chk("sat1_flag", b_sat_flag, 1);
    run(1'b1, 32767, 32767, "sat2");
    chk("sat2_flag", b_sat_flag, 1);
`else
    run(1'b1, 32767, 1, "wrap1");
    chk("wrap1_flag", b_sat_flag, 0);
    run(1'b1, 32767, 2, "wrap2");
    chk("wrap2_flag", b_sat_flag, 0);
`endif
    do_reset();
    chk("sat_clr_flag", b_sat_flag, 0);
    chk("sat_clr_data", b_out_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
